// File: rtl/osc_rst_pkg.sv
// Shared state encoding and counter sizing for the oscillator reset sequencer.
// Latency: n/a (declarations only); backpressure: none.
package osc_rst_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // Width that holds (largest cycle count - 1); never narrower than one bit.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/osc_rst_debounce.sv
// 2-FF synchroniser plus debounce counter for a bouncy async input; dout resets to 0.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles; backpressure: none.
module osc_rst_debounce
  import osc_rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES, 1, 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      cnt       <= '0;
      dout      <= 1'b0;
    end else begin
      sync_meta <= din;
      sync_q    <= sync_meta;
      // A single agreeing cycle restarts the qualification window.
      if (sync_q == dout) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        dout <= sync_q;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/osc_rst_sequencer.sv
// PLL reset / lock-qualify / fabric-release sequencer with retry, lock-loss and push-button handling.
// Latency: fabric release 3+LOCK_STABLE_CYCLES edges after lock goes high; backpressure: none.
module osc_rst_sequencer
  import osc_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int DEBOUNCE_CYCLES     = 1600,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       EXT_RST_N,
  input  logic       PLL_LOCK,
  output logic       PLL_ARST_N,
  output logic       FABRIC_RESET_N,
  output logic       LOCK_FAIL,
  output logic [2:0] STATE
);

  localparam int CW = cnt_w(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int RW = cnt_w(MAX_RETRIES + 1, 1, 1);
  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;
  logic          lock_meta;
  logic          lock_s;
  logic          btn_db;

  osc_rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk  (CLK),
    .rst_n(RESETN),
    .din  (EXT_RST_N),
    .dout (btn_db)
  );

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= PLL_LOCK;
      lock_s    <= lock_meta;
    end
  end

  assign STATE = state;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state          <= ST_PLL_RST;
      cnt            <= '0;
      retry          <= '0;
      PLL_ARST_N     <= 1'b0;
      FABRIC_RESET_N <= 1'b0;
      LOCK_FAIL      <= 1'b0;
    end else if (!btn_db) begin
      // FAIL is never entered with the button down, so level here covers the falling edge.
      state          <= ST_PLL_RST;
      cnt            <= '0;
      retry          <= '0;
      PLL_ARST_N     <= 1'b0;
      FABRIC_RESET_N <= 1'b0;
      LOCK_FAIL      <= 1'b0;
    end else begin
      unique case (state)
        ST_PLL_RST: begin
          if (cnt == RST_LAST) begin
            state      <= ST_WAIT_LOCK;
            cnt        <= '0;
            PLL_ARST_N <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt        <= '0;
            retry      <= retry + 1'b1;
            PLL_ARST_N <= 1'b0;
            if (retry == RETRY_LAST) begin
              state     <= ST_FAIL;
              LOCK_FAIL <= 1'b1;
            end else begin
              state <= ST_PLL_RST;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state          <= ST_RUN;
            cnt            <= '0;
            retry          <= '0;
            FABRIC_RESET_N <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state          <= ST_PLL_RST;
            cnt            <= '0;
            PLL_ARST_N     <= 1'b0;
            FABRIC_RESET_N <= 1'b0;
          end
        end
        ST_FAIL: begin
          PLL_ARST_N     <= 1'b0;
          FABRIC_RESET_N <= 1'b0;
          LOCK_FAIL      <= 1'b1;
        end
        default: begin
          state          <= ST_PLL_RST;
          cnt            <= '0;
          PLL_ARST_N     <= 1'b0;
          FABRIC_RESET_N <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osc_rst_sequencer.sv
// Directed bench for osc_rst_sequencer: bring-up, lock loss, lock glitch, RESETN, timeout/FAIL, bounce.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_osc_rst_sequencer;

  logic       CLK;
  logic       RESETN;
  logic       EXT_RST_N;
  logic       PLL_LOCK;
  logic       PLL_ARST_N;
  logic       FABRIC_RESET_N;
  logic       LOCK_FAIL;
  logic [2:0] STATE;

  int checks;
  int errors;

  osc_rst_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .DEBOUNCE_CYCLES    (4),
    .MAX_RETRIES        (2)
  ) dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .EXT_RST_N     (EXT_RST_N),
    .PLL_LOCK      (PLL_LOCK),
    .PLL_ARST_N    (PLL_ARST_N),
    .FABRIC_RESET_N(FABRIC_RESET_N),
    .LOCK_FAIL     (LOCK_FAIL),
    .STATE         (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    RESETN    = 1'b0;
    EXT_RST_N = 1'b1;
    PLL_LOCK  = 1'b1;
    step(3);
    chk("rst_state", STATE, 0);
    chk("rst_pll", PLL_ARST_N, 0);
    chk("rst_fab", FABRIC_RESET_N, 0);
    chk("rst_fail", LOCK_FAIL, 0);

    // Bring-up: button qualifies at edge 6, PLL_RST counts edges 7..10,
    // lock already synced so STABLE at 11, RUN after 8 stable edges at 19.
    RESETN = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      step(1);
      chk("bringup_state", STATE, (e < 10) ? 0 : (e == 10) ? 1 : (e < 19) ? 2 : 3);
      chk("bringup_pll", PLL_ARST_N, (e >= 10) ? 1 : 0);
      chk("bringup_fab", FABRIC_RESET_N, (e >= 19) ? 1 : 0);
    end
    chk("bringup_fail", LOCK_FAIL, 0);

    // Lock loss in RUN: two sync edges, then the FSM reacts on the third.
    step(1);
    PLL_LOCK = 1'b0;
    step(2);
    chk("loss_fab_held", FABRIC_RESET_N, 1);
    chk("loss_state_held", STATE, 3);
    step(1);
    chk("loss_fab", FABRIC_RESET_N, 0);
    chk("loss_state", STATE, 0);
    chk("loss_pll", PLL_ARST_N, 0);
    step(3);
    chk("loss_rst_hold", STATE, 0);
    chk("loss_rst_pll", PLL_ARST_N, 0);
    step(1);
    chk("loss_wait", STATE, 1);
    chk("loss_wait_pll", PLL_ARST_N, 1);

    // Fresh lock driven after edge k: STABLE at k+3, fabric release at k+3+8.
    PLL_LOCK = 1'b1;
    step(2);
    chk("lat_wait", STATE, 1);
    step(1);
    chk("lat_stable", STATE, 2);
    step(7);
    chk("lat_fab_lo", FABRIC_RESET_N, 0);
    step(1);
    chk("lat_fab_hi", FABRIC_RESET_N, 1);
    chk("lat_run", STATE, 3);

    // Lock glitch during STABLE at count 5 restarts qualification from WAIT_LOCK.
    PLL_LOCK = 1'b0;
    step(3);
    chk("gl_rst", STATE, 0);
    step(4);
    chk("gl_wait", STATE, 1);
    PLL_LOCK = 1'b1;
    step(8);
    chk("gl_stable5", STATE, 2);
    PLL_LOCK = 1'b0;
    step(1);
    PLL_LOCK = 1'b1;
    step(1);
    chk("gl_still_stable", STATE, 2);
    step(1);
    chk("gl_back_wait", STATE, 1);
    chk("gl_fab_lo0", FABRIC_RESET_N, 0);
    step(1);
    chk("gl_restable", STATE, 2);
    step(7);
    chk("gl_fab_lo", FABRIC_RESET_N, 0);
    step(1);
    chk("gl_fab_hi", FABRIC_RESET_N, 1);
    chk("gl_run", STATE, 3);
    chk("gl_retry", dut.retry, 0);

    // RESETN in RUN, then again in STABLE.
    RESETN = 1'b0;
    step(1);
    chk("rrun_state", STATE, 0);
    chk("rrun_pll", PLL_ARST_N, 0);
    chk("rrun_fab", FABRIC_RESET_N, 0);
    RESETN = 1'b1;
    step(14);
    chk("rstb_pre_state", STATE, 2);
    chk("rstb_pre_pll", PLL_ARST_N, 1);
    RESETN = 1'b0;
    step(1);
    chk("rstb_state", STATE, 0);
    chk("rstb_pll", PLL_ARST_N, 0);
    chk("rstb_fab", FABRIC_RESET_N, 0);

    // Timeout: WAIT_LOCK from edge 10, timeouts at 42 and 78, second one enters FAIL.
    PLL_LOCK = 1'b0;
    step(1);
    RESETN = 1'b1;
    step(41);
    chk("to_wait1", STATE, 1);
    chk("to_wait1_pll", PLL_ARST_N, 1);
    step(1);
    chk("to_retry_state", STATE, 0);
    chk("to_retry_pll", PLL_ARST_N, 0);
    step(4);
    chk("to_wait2", STATE, 1);
    chk("to_wait2_pll", PLL_ARST_N, 1);
    step(31);
    chk("to_wait2_end", STATE, 1);
    chk("to_nofail_yet", LOCK_FAIL, 0);
    step(1);
    chk("to_fail_state", STATE, 4);
    chk("to_fail_flag", LOCK_FAIL, 1);
    chk("to_fail_pll", PLL_ARST_N, 0);
    chk("to_fail_fab", FABRIC_RESET_N, 0);
    step(50);
    chk("to_sticky_state", STATE, 4);
    chk("to_sticky_flag", LOCK_FAIL, 1);
    chk("to_sticky_pll", PLL_ARST_N, 0);

    // Bounce: 2-cycle toggles never qualify; a steady press exits FAIL at b+7.
    for (int i = 0; i < 10; i++) begin
      EXT_RST_N = 1'b0;
      step(2);
      EXT_RST_N = 1'b1;
      step(2);
      chk("bounce_state", STATE, 4);
    end
    chk("bounce_flag", LOCK_FAIL, 1);
    EXT_RST_N = 1'b0;
    step(6);
    chk("press_pre", STATE, 4);
    step(1);
    chk("press_state", STATE, 0);
    chk("press_flag", LOCK_FAIL, 0);
    chk("press_pll", PLL_ARST_N, 0);
    step(5);
    chk("press_hold", STATE, 0);
    chk("press_hold_pll", PLL_ARST_N, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
